// File: rtl/rollover_event_timer.sv
// rollover_event_timer: counts carry-out events from an upstream counter into a
// WIDTH-bit accumulator and emits a one-cycle registered tick each time the
// accumulated count reaches the programmable match value (0 = 2^WIDTH events).
// The timer runs in periodic or one-shot mode; the mode is captured on start.
// Optional build macro ROLLOVER_EDGE_DETECT_EN: when defined, one event is a
// 0->1 transition of carry_in. Otherwise every cycle with carry_in=1 counts.
module rollover_event_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carry_in,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] match,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term;
  logic             tick_q, tick_d;
  logic             busy_q, done_q;
  logic             oneshot_q, oneshot_d;
  logic             evt;
  logic             hit;

`ifdef ROLLOVER_EDGE_DETECT_EN
  logic carry_prev_q;

  // History flop for the rising-edge detector; clears so a level held since reset counts once
  always_ff @(posedge clk) begin
    if (rst) carry_prev_q <= 1'b0;
    else     carry_prev_q <= carry_in;
  end

  assign evt = carry_in & ~carry_prev_q;
`else
  assign evt = carry_in;
`endif

  // match-1 wraps naturally, so match=0 compares against all-ones
  assign term = match - WIDTH'(1);
  assign hit  = evt && (count_q == term);

  // State register plus registered outputs and latched mode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      busy_q    <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
      oneshot_q <= oneshot_d;
    end
  end

  // Next-state: stop beats start, start beats a carry event
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!stop && start) state_d = S_RUN;
      S_RUN: begin
        if (stop)                      state_d = S_IDLE;
        else if (start)                state_d = S_RUN;
        else if (hit && oneshot_q)     state_d = S_DONE;
      end
      S_DONE: begin
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: accumulator, tick and mode latch per state
  always_comb begin
    count_d   = count_q;
    tick_d    = 1'b0;
    oneshot_d = oneshot_q;
    case (state_q)
      S_IDLE: begin
        if (!stop && start) begin
          count_d   = '0;
          oneshot_d = oneshot;
        end
      end
      S_RUN: begin
        if (stop) begin
          count_d = count_q;
        end else if (start) begin
          count_d   = '0;
          oneshot_d = oneshot;
        end else if (hit) begin
          count_d = '0;
          tick_d  = 1'b1;
        end else if (evt) begin
          count_d = count_q + WIDTH'(1);
        end
      end
      S_DONE: begin
        count_d = '0;
        if (!stop && start) oneshot_d = oneshot;
      end
      default: count_d = '0;
    endcase
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
